seg7_disp_ctrl: RTL



---
 rtl/seg7_disp_ctrl_if.sv | 14 +
 rtl/seg7_disp_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/seg7_disp_ctrl_if.sv
// Bus bundle between the counter/clock logic (master) and seg7_disp_ctrl (slave).
interface seg7_disp_ctrl_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] din;
  logic              load;
  logic              en;
  logic [NDIG-1:0]   blink_mask;
  logic              blink_ph;
  logic [7*NDIG-1:0] n_hex;

  modport master (output din, load, en, blink_mask, input blink_ph, n_hex);
  modport slave  (input din, load, en, blink_mask, output blink_ph, n_hex);
endinterface

// File: rtl/seg7_disp_ctrl.sv
// Registered NDIG-digit 7-segment controller: digit capture, blink, enable, hex glyphs.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_disp_ctrl #(
  parameter int NDIG      = 4,
  parameter int BLINK_DIV = 25_000_000,
  parameter int HEX_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  seg7_disp_ctrl_if.slave   bus
);

  localparam int            CW       = $clog2(BLINK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(BLINK_DIV - 1);

  logic [4*NDIG-1:0] dig_d, dig_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic              blink_ph_d, blink_ph_q;
  logic [7*NDIG-1:0] n_hex_d, n_hex_q;
  logic [NDIG-1:0]   lzb_s;

  // Active-low g..a glyph for one 4-bit digit code.
  function automatic logic [6:0] decode_glyph(input logic [3:0] code);
    logic [6:0] glyph;
    case (code)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1011000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = (HEX_MODE != 0) ? 7'b0001000 : 7'b1111111;
      4'hB:    glyph = (HEX_MODE != 0) ? 7'b0000011 : 7'b1111111;
      4'hC:    glyph = (HEX_MODE != 0) ? 7'b1000110 : 7'b1111111;
      4'hD:    glyph = (HEX_MODE != 0) ? 7'b0100001 : 7'b1111111;
      4'hE:    glyph = (HEX_MODE != 0) ? 7'b0000110 : 7'b1111111;
      4'hF:    glyph = (HEX_MODE != 0) ? 7'b0001110 : 7'b1111111;
      default: glyph = 7'b1111111;
    endcase
    return glyph;
  endfunction

`ifdef SEG7_LZB_EN
  // A digit above 0 is dark while it and every digit above it hold code 0.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lzb_s    = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run = zero_run & (dig_q[4*i +: 4] == 4'h0);
      lzb_s[i] = zero_run & (i != 0);
    end
  end
`else
  assign lzb_s = '0;
`endif

  // Next-state for digit capture, blink divider and the glyph output stage.
  always_comb begin
    if (bus.load) begin
      dig_d = bus.din;
    end else begin
      dig_d = dig_q;
    end

    if (cnt_q == DIV_LAST) begin
      cnt_d      = '0;
      blink_ph_d = ~blink_ph_q;
    end else begin
      cnt_d      = cnt_q + CW'(1);
      blink_ph_d = blink_ph_q;
    end

    n_hex_d = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (!bus.en || (bus.blink_mask[i] && blink_ph_q) || lzb_s[i]) begin
        n_hex_d[7*i +: 7] = 7'b1111111;
      end else begin
        n_hex_d[7*i +: 7] = decode_glyph(dig_q[4*i +: 4]);
      end
    end
  end

  // State registers; reset overrides capture and the divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q      <= '0;
      cnt_q      <= '0;
      blink_ph_q <= 1'b0;
      n_hex_q    <= '1;
    end else begin
      dig_q      <= dig_d;
      cnt_q      <= cnt_d;
      blink_ph_q <= blink_ph_d;
      n_hex_q    <= n_hex_d;
    end
  end

  assign bus.blink_ph = blink_ph_q;
  assign bus.n_hex    = n_hex_q;

endmodule
